// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, types and helper functions for the AES
//                key-schedule block (word count helpers, RotWord, xtime and
//                the expansion FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int BYTE_SIZE = 8;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_t;

    // Number of 32-bit words in the cipher key.
    function automatic int nk_f(input int key_size);
        return key_size / 32;
    endfunction

    // Number of cipher rounds for the given key size.
    function automatic int nr_f(input int key_size);
        return (key_size / 32) + 6;
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word_f(input logic [31:0] word);
        return {word[23:0], word[31:24]};
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime_f(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_word
//  Description : Combinational SubWord: applies the AES S-box to each of the
//                four bytes of a 32-bit word.
//  Ports       : sub_in  [31:0] - word to substitute
//                sub_out [31:0] - substituted word
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] sub_in,
    output logic [31:0] sub_out
);

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign sub_out[b*BYTE_SIZE +: BYTE_SIZE] = c_SBOX[sub_in[b*BYTE_SIZE +: BYTE_SIZE]];
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_schedule
//  Description : AES key expansion for 128/192/256-bit keys. Accepts a key
//                over a valid/ready handshake, expands one schedule word per
//                cycle, then exposes every round key on a random-access read
//                port.
//  Ports       : clk, rst_n (async, active-low)
//                key_valid/key_ready/in_key  - key load handshake
//                keys_valid                  - round keys readable
//                done                        - one-cycle completion pulse
//                rd_round/rd_key             - round-key read port
//  Config      : AES_KEY_SCHEDULE_RD_REG_EN - when defined, rd_key is
//                registered (one-cycle latency, resets to zero); otherwise
//                rd_key is combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule #(
    parameter int KEY_SIZE  = 128,
    parameter int WORD_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_SIZE-1:0] in_key,
    output logic                keys_valid,
    output logic                done,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);
    import aes_pkg::*;

    localparam int         c_NK      = nk_f(KEY_SIZE);
    localparam int         c_NR      = nr_f(KEY_SIZE);
    localparam int         c_NW      = 4 * (c_NR + 1);
    localparam int         c_WORDS   = 60;
    localparam logic [5:0] c_NK_W    = 6'(c_NK);
    localparam logic [5:0] c_LAST_W  = 6'(c_NW - 1);
    localparam logic [3:0] c_NR_W    = 4'(c_NR);

    if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key_size
        $error("aes_key_schedule: KEY_SIZE must be 128, 192 or 256");
    end
    if (WORD_SIZE != 32) begin : g_bad_word_size
        $error("aes_key_schedule: WORD_SIZE must be 32");
    end

    ks_state_t            r_state;
    logic [5:0]           r_i;
    logic [7:0]           r_rcon;
    logic                 r_keys_valid;
    logic [WORD_SIZE-1:0] r_w [c_WORDS];

    logic [5:0]           w_i_mod;
    logic [31:0]          w_temp;
    logic [31:0]          w_back;
    logic [31:0]          w_sub_in;
    logic [31:0]          w_sub_out;
    logic [31:0]          w_f;
    logic [31:0]          w_new;

    assign w_i_mod  = r_i % c_NK_W;
    assign w_temp   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - c_NK_W];

    // A single SubWord unit serves both the rotated (i mod Nk == 0) and the
    // plain (256-bit, i mod 8 == 4) substitutions; the rotate is applied on
    // its input only when needed.
    assign w_sub_in = (w_i_mod == 6'd0) ? rot_word_f(w_temp) : w_temp;

    aes_sub_word u_sub_word (
        .sub_in  (w_sub_in),
        .sub_out (w_sub_out)
    );

    always_comb begin
        w_f = w_temp;
        if (w_i_mod == 6'd0) begin
            w_f = w_sub_out ^ {r_rcon, 24'h0};
        end else if (c_NK == 8 && w_i_mod == 6'd4) begin
            w_f = w_sub_out;
        end
    end

    assign w_new = w_back ^ w_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= KS_IDLE;
            r_i          <= 6'd0;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
            for (int k = 0; k < c_WORDS; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            case (r_state)
                KS_IDLE: begin
                    if (key_valid) begin
                        for (int k = 0; k < c_NK; k++) begin
                            r_w[k] <= in_key[KEY_SIZE-1-WORD_SIZE*k -: WORD_SIZE];
                        end
                        r_i          <= c_NK_W;
                        r_rcon       <= 8'h01;
                        r_keys_valid <= 1'b0;
                        r_state      <= KS_EXPAND;
                    end
                end
                KS_EXPAND: begin
                    r_w[r_i] <= w_new;
                    r_i      <= r_i + 6'd1;
                    if (w_i_mod == 6'd0) begin
                        r_rcon <= xtime_f(r_rcon);
                    end
                    // keys_valid rises together with done: every word is
                    // already stored when DONE is entered.
                    if (r_i == c_LAST_W) begin
                        r_state      <= KS_DONE;
                        r_keys_valid <= 1'b1;
                    end
                end
                KS_DONE: begin
                    r_state <= KS_IDLE;
                end
                default: begin
                    r_state <= KS_IDLE;
                end
            endcase
        end
    end

    assign key_ready  = (r_state == KS_IDLE);
    assign done       = (r_state == KS_DONE);
    assign keys_valid = r_keys_valid;

    // Read port: round r occupies words 4r..4r+3. Indices past Nr read as
    // zero, which also masks the out-of-range word addresses for r >= 15.
    logic [5:0]   w_rd_base;
    logic [127:0] w_rd_key;

    assign w_rd_base = {rd_round, 2'b00};
    assign w_rd_key  = (rd_round > c_NR_W) ? 128'h0 :
                       {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                        r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};

`ifdef AES_KEY_SCHEDULE_RD_REG_EN
    logic [127:0] r_rd_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key <= 128'h0;
        end else begin
            r_rd_key <= w_rd_key;
        end
    end

    assign rd_key = r_rd_key;
`else
    assign rd_key = w_rd_key;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_schedule
//  Description : Self-checking bench for aes_key_schedule. One instance per
//                key size; round keys are predicted by an independent model
//                whose S-box is derived from GF(2^8) inversion plus the
//                affine map, and cross-checked against published vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [255:0]       key_bus;
    logic [3:0]         rd_round;
    logic [2:0]         kv;
    logic [2:0]         kr;
    logic [2:0]         ksv;
    logic [2:0]         dn;
    logic [2:0][127:0]  rk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]   sb_m [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_SIZE(128)) u_ks128 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]),
        .in_key(key_bus[255:128]), .keys_valid(ksv[0]), .done(dn[0]),
        .rd_round(rd_round), .rd_key(rk[0]));

    aes_key_schedule #(.KEY_SIZE(192)) u_ks192 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]),
        .in_key(key_bus[255:64]), .keys_valid(ksv[1]), .done(dn[1]),
        .rd_round(rd_round), .rd_key(rk[1]));

    aes_key_schedule #(.KEY_SIZE(256)) u_ks256 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]),
        .in_key(key_bus), .keys_valid(ksv[2]), .done(dn[2]),
        .rd_round(rd_round), .rd_key(rk[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] x);
        return {sb_m[x[31:24]], sb_m[x[23:16]], sb_m[x[15:8]], sb_m[x[7:0]]};
    endfunction

    function automatic logic [127:0] model_round(input int nk, input logic [255:0] key, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nw = 4 * (nk + 7);
        if (r > nk + 6) return 128'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_m(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- stimulus tasks ----------------
    // mode 0: plain expansion, 1: extra key_valid mid-expansion,
    // 2: reset pulsed at EXPAND cycle 20. Returns at the negedge of the
    // DONE cycle (modes 0/1).
    task automatic run_key(input int d, input logic [255:0] key, input int mode);
        int cyc  = 0;
        int wt   = 0;
        int nk   = 4 + 2*d;
        int lat  = 4*(nk + 7) - nk + 1;
        bit seen = 1'b0;
        while (!kr[d] && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk($sformatf("ready_wait_d%0d", d), kr[d], 1'b1);
        key_bus = key;
        kv[d]   = 1'b1;
        @(posedge clk);
        #1 kv[d] = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk($sformatf("kv_drop_d%0d", d), ksv[d], 1'b0);
            if (mode == 1 && cyc == 10) begin
                chk("busy_ready", kr[d], 1'b0);
                key_bus = ~key;
                kv[d]   = 1'b1;
            end
            if (mode == 1 && cyc == 11) begin
                chk("busy_ready2", kr[d], 1'b0);
                kv[d] = 1'b0;
            end
            if (mode == 2 && cyc == 20) rst_n = 1'b0;
            if (mode == 2 && cyc == 22) rst_n = 1'b1;
            if (dn[d]) seen = 1'b1;
        end
        if (mode == 2) begin
            chk("rst_no_done", seen, 1'b0);
            chk("rst_kvalid", ksv[d], 1'b0);
            chk("rst_ready", kr[d], 1'b1);
        end else begin
            chk($sformatf("done_lat_d%0d", d), cyc, lat);
            chk($sformatf("done_kvalid_d%0d", d), ksv[d], 1'b1);
            chk($sformatf("done_notready_d%0d", d), kr[d], 1'b0);
        end
    endtask

    task automatic read_one(input int d, input int r, input logic [127:0] exp, input string tag);
        @(posedge clk);
        #1 rd_round = 4'(r);
        exp_q.push_back(exp);
`ifdef AES_KEY_SCHEDULE_RD_REG_EN
        @(posedge clk);
`endif
        @(negedge clk);
        chk(tag, rk[d], exp_q.pop_front());
    endtask

    task automatic read_all(input int d, input logic [255:0] key);
        for (int r = 0; r < 16; r++) begin
            read_one(d, r, model_round(4 + 2*d, key, r), $sformatf("d%0d_round%0d", d, r));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] k128, k192, k256, kb, kc;
        k128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
        k256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
        kb   = {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0};
        kc   = {$urandom, $urandom, $urandom, $urandom, 128'h0};

        build_sbox();
        rst_n    = 1'b0;
        kv       = 3'b000;
        key_bus  = '0;
        rd_round = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", kr, 3'b111);
        chk("reset_kvalid", ksv, 3'b000);
        chk("reset_done", dn, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", kr, 3'b111);

        // AES-128
        run_key(0, k128, 0);
        read_all(0, k128);
        read_one(0, 1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605, "v128_round1");
        read_one(0, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "v128_round10");

        // AES-192
        run_key(1, k192, 0);
        read_all(1, k192);
        read_one(1, 12, 128'he98ba06f_448c773c_8ecc7204_01002202, "v192_round12");
        read_one(1, 13, 128'h0, "v192_round13");

        // AES-256
        run_key(2, k256, 0);
        read_all(2, k256);
        read_one(2, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e, "v256_round14");

        // Busy handshake ignored
        run_key(0, k128, 1);
        read_one(0, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "busy_round10");
        read_one(0, 0, k128[255:128], "busy_round0");

        // Reset mid-expansion, then a clean expansion
        run_key(0, kb, 2);
        run_key(0, kb, 0);
        read_all(0, kb);

        // Back-to-back: second key accepted the cycle after done
        run_key(0, k128, 0);
        run_key(0, kc, 0);
        read_one(0, 10, model_round(4, kc, 10), "b2b_round10");
        read_all(0, kc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameter KEY_SIZE, default 128: cipher key width; the block SHALL support only 128, 192 and 256, and SHALL fail elaboration for any other value.
REQ-002 Parameter WORD_SIZE, default 32: key-schedule word width; the block SHALL fix it at 32.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_valid  input  1  in_key is valid this cycle.
REQ-006 key_ready  output  1  block can accept a key.
REQ-007 in_key  input  KEY_SIZE  cipher key; word w[0] is the MSBs.
REQ-008 keys_valid  output  1  every round key is available on the read port.
REQ-009 done  output  1  one-cycle pulse when expansion completes.
REQ-010 rd_round  input  4  round-key index, 0..Nr.
REQ-011 rd_key  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

Function
REQ-012 Derived constants SHALL be Nk = KEY_SIZE/32, Nr = Nk+6 and Nw = 4*(Nr+1), giving 44, 52 or 60 words.
REQ-013 The FSM SHALL have three states, IDLE, EXPAND and DONE, and key_ready SHALL be 1 only in IDLE.
REQ-014 A handshake (key_valid && key_ready) SHALL load w[0..Nk-1] from in_key, set i=Nk, set rcon=0x01, clear keys_valid, and move to EXPAND.
REQ-015 In EXPAND, the block SHALL compute exactly one word per cycle with temp=w[i-1] and w[i]=w[i-Nk]^f(temp).
REQ-016 The function f SHALL be:
- i mod Nk == 0: SubWord(RotWord(temp))^{rcon,24'h0}, then rcon <= xtime(rcon).
- Nk == 8 and i mod Nk == 4: SubWord(temp).
- otherwise: temp.
REQ-017 xtime SHALL be {rcon[6:0],1'b0}^(rcon[7] ? 8'h1B : 8'h00), producing the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-018 After writing w[Nw-1], the FSM SHALL enter DONE, so EXPAND lasts exactly Nw-Nk cycles (40, 46 or 52).
REQ-019 DONE SHALL last one cycle, assert done for that cycle, set keys_valid, and return to IDLE.
REQ-020 keys_valid SHALL remain 1 until the next accepted key or reset.
REQ-021 key_valid SHALL be ignored while key_ready is 0; no queuing and no corruption of the expansion in progress.
REQ-022 rd_key SHALL be combinational from rd_round and the stored words, and SHALL be 128'h0 when rd_round > Nr.
REQ-023 rd_key SHALL be undefined-but-stable while keys_valid is 0; the bench SHALL NOT check it then.
REQ-024 A key accepted in the same cycle that DONE returns to IDLE SHALL be impossible, because key_ready is 0 in DONE.

Reset
REQ-025 Reset SHALL force IDLE, key_ready=1 (after reset), keys_valid=0, done=0, i=0, rcon=0x01, and all stored words to 0.
REQ-026 Reset asserted during EXPAND SHALL abort expansion immediately; keys_valid SHALL NOT be set, and no done pulse SHALL appear.

Configuration
REQ-027 Macro AES_KEY_SCHEDULE_RD_REG_EN SHALL control the read path:
- Defined: rd_key is registered, one-cycle latency from rd_round, reset value 128'h0.
- Undefined: rd_key is combinational, zero latency.
- In both cases, expansion timing SHALL be unchanged.

Structure
REQ-028 aes_pkg SHALL hold:
- functions nk_f(KEY_SIZE), nr_f(KEY_SIZE), rot_word_f and xtime_f.
- the FSM state enum ks_state_t.
- localparam BYTE_SIZE=8.
REQ-029 Sub-module aes_sub_word SHALL be combinational: four S-box byte lookups on one 32-bit word, instantiated once.
REQ-030 Word storage SHALL be a register array of 60 x 32 bits, with indices >= Nw unused.

Verification
REQ-031 AES-128 vector:
- Stimulus: key 2b7e1516_28aed2a6_abf71588_09cf4f3c.
- Required: w[4]=a0fafe17; rd_round=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done appears 41 cycles after the handshake.
REQ-032 AES-192 vector:
- Stimulus: key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b.
- Required: rd_round=12 gives e98ba06f_448c773c_8ecc7204_01002202; rd_round=13 gives 0.
REQ-033 AES-256 vector:
- Stimulus: key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4.
- Required: rd_round=14 gives fe4890d1_e6188d0b_046df344_706c631e; this exercises the i mod 8 == 4 SubWord path.
REQ-034 Busy handshake:
- Stimulus: a second key_valid pulse, with a different key, mid-EXPAND.
- Required: key_ready stays 0, and final keys match the first key only.
REQ-035 Reset mid-operation:
- Stimulus: rst_n pulsed low at cycle 20 of EXPAND.
- Required: keys_valid=0, done is never pulsed, and key_ready=1 after reset; a new key then expands correctly.
REQ-036 Back-to-back keys:
- Stimulus: an AES-128 key accepted the cycle after done.
- Required: keys_valid drops on acceptance and rises again with the new round-10 key.
